// File: rtl/fpu_pkg.sv
// Shared FPU types and constants used by the multiplier arbiter.
package fpu_pkg;

    localparam int FP32_WIDTH = 32;

    // Default quiet NaN returned when an operation times out.
    localparam logic [FP32_WIDTH-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ISSUE       = 2'd1,
        WAIT_RESULT = 2'd2,
        DRAIN       = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fpu_mul_arbiter_if.sv
// Requester-side bus of the shared multiplier: per-requester requests and
// the routed response.
//
// Handshake: a requester raises req_valid[i] with req_a/req_b slice i and
// holds them until req_ready[i] pulses for one cycle; the request is taken
// on that pulse and req_valid[i] must drop the following cycle, otherwise
// it counts as a fresh request. The answer comes back later as a one-cycle
// resp_valid[i] pulse with resp_data/resp_err; responses cannot be stalled.
interface fpu_mul_arbiter_if
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FP32_WIDTH-1:0] req_a;
    logic [NUM_REQ*FP32_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [FP32_WIDTH-1:0]         resp_data;
    logic                          resp_err;

    // Requesters drive the request side.
    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // The arbiter accepts requests and returns responses.
    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/fpu_rr_arbiter.sv
// Combinational masked round-robin picker: the lowest requesting index at or
// above ptr wins; if none, the lowest requesting index overall wins.
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] masked_req;
    logic [PTR_W-1:0]   lo_masked;
    logic [PTR_W-1:0]   lo_all;

    // Priority search over the masked and unmasked request vectors.
    always_comb begin
        mask       = '0;
        lo_masked  = '0;
        lo_all     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        masked_req = req & mask;
        // Walk downward so the lowest set index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked_req[i]) lo_masked = PTR_W'(i);
            if (req[i])        lo_all    = PTR_W'(i);
        end
        any       = |req;
        grant_idx = (|masked_req) ? lo_masked : lo_all;
        grant     = any ? (ONE << grant_idx) : '0;
    end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fpu_mul among NUM_REQ issue slots: round-robin grant, one
// operation in flight, result routed back to its issuer, and a watchdog that
// answers hung operations with a NaN error and swallows the late result.
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    fpu_mul_arbiter_if.slave      bus,
    output logic                  mul_valid,
    output logic [FP32_WIDTH-1:0] mul_din1,
    output logic [FP32_WIDTH-1:0] mul_din2,
    input  logic                  mul_ready,
    input  logic [FP32_WIDTH-1:0] mul_result,
    output logic                  busy,
    output logic [7:0]            timeout_count,
    output arb_state_t            dbg_state
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE        = NUM_REQ'(1);

    arb_state_t            state, state_nxt;
    logic [PTR_W-1:0]      grant_idx, grant_nxt;
    logic [PTR_W-1:0]      rr_ptr, ptr_nxt;
    logic [TIMER_W-1:0]    timer, timer_nxt;
    logic [FP32_WIDTH-1:0] din1_nxt, din2_nxt;
    logic                  mul_valid_nxt;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_nxt;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_nxt;
    logic [FP32_WIDTH-1:0] resp_data_q, resp_data_nxt;
    logic                  resp_err_q, resp_err_nxt;
    logic                  busy_nxt;
    logic [7:0]            tcount_nxt;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_any;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_idx;
        ptr_nxt        = rr_ptr;
        timer_nxt      = timer;
        din1_nxt       = mul_din1;
        din2_nxt       = mul_din2;
        tcount_nxt     = timeout_count;
        req_ready_nxt  = '0;
        mul_valid_nxt  = 1'b0;
        resp_valid_nxt = '0;
        resp_data_nxt  = resp_data_q;
        resp_err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_nxt     = arb_idx;
                    din1_nxt      = bus.req_a[arb_idx*FP32_WIDTH +: FP32_WIDTH];
                    din2_nxt      = bus.req_b[arb_idx*FP32_WIDTH +: FP32_WIDTH];
                    ptr_nxt       = (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
                    req_ready_nxt = arb_grant;
                    mul_valid_nxt = 1'b1;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                timer_nxt = '0;
                state_nxt = WAIT_RESULT;
            end
            WAIT_RESULT: begin
                if (mul_ready) begin
                    resp_valid_nxt = ONE << grant_idx;
                    resp_data_nxt  = mul_result;
                    state_nxt      = IDLE;
                end else if (timer == TIMER_LAST) begin
                    // Answer the issuer now; the real result is dropped in DRAIN.
                    resp_valid_nxt = ONE << grant_idx;
                    resp_data_nxt  = FP32_QNAN;
                    resp_err_nxt   = 1'b1;
                    tcount_nxt     = (timeout_count == 8'hFF) ? 8'hFF : timeout_count + 8'd1;
                    state_nxt      = DRAIN;
                end else begin
                    timer_nxt = timer + TIMER_W'(1);
                end
            end
            DRAIN: begin
                if (mul_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            grant_idx     <= '0;
            rr_ptr        <= '0;
            timer         <= '0;
            mul_din1      <= '0;
            mul_din2      <= '0;
            mul_valid     <= 1'b0;
            req_ready_q   <= '0;
            resp_valid_q  <= '0;
            resp_data_q   <= '0;
            resp_err_q    <= 1'b0;
            busy          <= 1'b0;
            timeout_count <= '0;
        end else begin
            state         <= state_nxt;
            grant_idx     <= grant_nxt;
            rr_ptr        <= ptr_nxt;
            timer         <= timer_nxt;
            mul_din1      <= din1_nxt;
            mul_din2      <= din2_nxt;
            mul_valid     <= mul_valid_nxt;
            req_ready_q   <= req_ready_nxt;
            resp_valid_q  <= resp_valid_nxt;
            resp_data_q   <= resp_data_nxt;
            resp_err_q    <= resp_err_nxt;
            busy          <= busy_nxt;
            timeout_count <= tcount_nxt;
        end
    end

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: behavioural multiplier stub, randomized
// requesters, a grant/response scoreboard and directed corner scenarios.
module tb_fpu_mul_arbiter;
    import fpu_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int NPAIR = 7;

    // Exactly representable products, plus Inf*0.
    localparam logic [31:0] PAIR_A [NPAIR] = '{32'h40000000, 32'h3FC00000, 32'h7F800000,
        32'h3F800000, 32'h3F000000, 32'hC0000000, 32'h40400000};
    localparam logic [31:0] PAIR_B [NPAIR] = '{32'h40400000, 32'h40000000, 32'h00000000,
        32'h3F800000, 32'h40800000, 32'h40200000, 32'h40400000};
    localparam logic [31:0] PAIR_P [NPAIR] = '{32'h40C00000, 32'h40400000, 32'hFFC00000,
        32'h3F800000, 32'h40000000, 32'hC0A00000, 32'h41100000};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fpu_mul_arbiter_if #(.NUM_REQ(N)) bus();
    logic        mul_valid;
    logic [31:0] mul_din1, mul_din2;
    logic        mul_ready = 1'b0;
    logic [31:0] mul_result = '0;
    logic        busy;
    logic [7:0]  timeout_count;
    arb_state_t  dbg_state;

    fpu_mul_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .mul_valid(mul_valid), .mul_din1(mul_din1), .mul_din2(mul_din2),
        .mul_ready(mul_ready), .mul_result(mul_result),
        .busy(busy), .timeout_count(timeout_count), .dbg_state(dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Multiplier behaviour: IEEE products for the table, a fixed scramble otherwise.
    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        for (int k = 0; k < NPAIR; k++)
            if (PAIR_A[k] == a && PAIR_B[k] == b) return PAIR_P[k];
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v = '0;
        if (k >= 0 && k < N) v[k] = 1'b1;
        return v;
    endfunction

    function automatic int model_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    // ---------------- multiplier stub ----------------
    logic        stub_hang = 1'b0;
    logic        stub_busy = 1'b0;
    int          stub_cnt = 0;
    logic [31:0] op_a, op_b;
    int          late_req = 0;
    int          late_done = 0;

    always @(negedge clk) begin
        mul_ready = 1'b0;
        if (!reset) begin
            stub_busy = 1'b0;
        end else begin
            if (stub_busy && !stub_hang) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    mul_ready  = 1'b1;
                    mul_result = fake_mul(op_a, op_b);
                    stub_busy  = 1'b0;
                end
            end
            if (mul_valid) begin
                op_a      = mul_din1;
                op_b      = mul_din2;
                stub_busy = 1'b1;
                stub_cnt  = $urandom_range(5, 1);
            end
        end
        if (late_done != late_req) begin
            late_done  = late_req;
            mul_ready  = 1'b1;
            mul_result = 32'h12345678;
            stub_busy  = 1'b0;
        end
    end

    // ---------------- requester drivers ----------------
    int          send_left [N];
    int          raise_pct = 100;
    logic        force_en [N];
    logic [31:0] force_a [N];
    logic [31:0] force_b [N];
    logic [36:0] exp_q [$];   // {err, idx[3:0], data}

    task automatic load_op(input int i);
        logic [31:0] a, b;
        int k;
        if (force_en[i]) begin
            a = force_a[i];
            b = force_b[i];
        end else if ($urandom_range(1, 0) == 1) begin
            k = $urandom_range(NPAIR - 1, 0);
            a = PAIR_A[k];
            b = PAIR_B[k];
        end else begin
            a = $urandom;
            b = $urandom;
        end
        bus.req_a[i*32 +: 32] = a;
        bus.req_b[i*32 +: 32] = b;
    endtask

    task automatic push_expected(input int i);
        logic [31:0] d;
        logic e;
        e = stub_hang;
        d = e ? 32'h7FC00000 : fake_mul(bus.req_a[i*32 +: 32], bus.req_b[i*32 +: 32]);
        exp_q.push_back({e, 4'(i), d});
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (reset && bus.req_ready[i]) begin
                    push_expected(i);
                    bus.req_valid[i] = 1'b0;
                end
                if (!bus.req_valid[i] && send_left[i] > 0 && $urandom_range(99, 0) < raise_pct) begin
                    load_op(i);
                    bus.req_valid[i] = 1'b1;
                    send_left[i]--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int            cyc = 0;
    int            issue_cyc = 0;
    int            model_ptr = 0;
    int            model_tmo = 0;
    logic [N-1:0]  prev_valid = '0;
    logic [N*32-1:0] prev_a = '0;
    logic [N*32-1:0] prev_b = '0;
    int            grant_log [$];
    logic [31:0]   last_data [N];
    logic          last_err [N];

    initial begin
        logic [36:0] e;
        int g, act;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                if (mul_valid || bus.req_ready != '0)
                    check("issue_pair", {63'd0, mul_valid}, {63'd0, bus.req_ready != '0});
                if (bus.req_ready != '0) begin
                    g = model_grant(prev_valid, model_ptr);
                    check("grant", bus.req_ready, onehot(g));
                    act = -1;
                    for (int i = 0; i < N; i++) if (bus.req_ready[i]) act = i;
                    grant_log.push_back(act);
                    if (g >= 0) begin
                        check("issue_din1", mul_din1, prev_a[g*32 +: 32]);
                        check("issue_din2", mul_din2, prev_b[g*32 +: 32]);
                        model_ptr = (g + 1) % N;
                    end
                    issue_cyc = cyc;
                end
                if (bus.resp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", bus.resp_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_onehot", bus.resp_valid, onehot(int'(e[35:32])));
                        check("resp_data", bus.resp_data, e[31:0]);
                        check("resp_err", bus.resp_err, e[36]);
                        if (e[36]) begin
                            model_tmo = (model_tmo == 255) ? 255 : model_tmo + 1;
                            check("timeout_latency", cyc - issue_cyc, TMO + 1);
                        end
                        check("timeout_count", timeout_count, model_tmo);
                        last_data[int'(e[35:32])] = bus.resp_data;
                        last_err[int'(e[35:32])]  = bus.resp_err;
                    end
                end
            end
            prev_valid = bus.req_valid;
            prev_a = bus.req_a;
            prev_b = bus.req_b;
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic wait_quiet(input string name, input int budget);
        int c = 0;
        bit done = 0;
        while (c < budget && !done) begin
            @(negedge clk);
            c++;
            done = (bus.req_valid == '0) && (exp_q.size() == 0) && !busy;
            for (int i = 0; i < N; i++) if (send_left[i] != 0) done = 0;
        end
        check(name, {63'd0, done}, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_q.delete();
        model_ptr = 0;
        model_tmo = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input int n);
        force_en[i] = 1'b1;
        force_a[i]  = a;
        force_b[i]  = b;
        send_left[i] = n;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
        check({tag, "_resp_data"}, bus.resp_data, 0);
        check({tag, "_resp_err"}, bus.resp_err, 0);
        check({tag, "_mul_valid"}, mul_valid, 0);
        check({tag, "_din"}, {mul_din1, mul_din2}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_tcount"}, timeout_count, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int c;
        for (int i = 0; i < N; i++) begin
            send_left[i] = 0;
            force_en[i] = 1'b0;
            force_a[i] = '0;
            force_b[i] = '0;
            last_data[i] = '0;
            last_err[i] = 1'b0;
        end
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;

        // 2.0 * 3.0 from requester 0
        @(negedge clk);
        set_op(0, 32'h40000000, 32'h40400000, 1);
        wait_quiet("t1_quiet", 200);
        check("t1_data", last_data[0], 32'h40C00000);
        check("t1_err", last_err[0], 0);

        // all four requesting from reset: rotation 0,1,2,3,0
        do_reset();
        @(negedge clk);
        grant_log.delete();
        set_op(0, 32'h3FC00000, 32'h40000000, 2);
        set_op(1, 32'h40000000, 32'h40400000, 2);
        set_op(2, 32'h3F000000, 32'h40800000, 2);
        set_op(3, 32'h40400000, 32'h40400000, 2);
        wait_quiet("t2_quiet", 400);
        check("t2_count", grant_log.size(), 8);
        if (grant_log.size() >= 5) begin
            check("t2_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0],
                               grant_log[3][7:0], grant_log[4][7:0]}, 40'h00_01_02_03_00);
        end
        check("t2_data0", last_data[0], 32'h40400000);
        check("t2_data1", last_data[1], 32'h40C00000);
        check("t2_data2", last_data[2], 32'h40000000);
        check("t2_data3", last_data[3], 32'h41100000);

        // Inf * 0 -> NaN from the multiplier, not an error
        @(negedge clk);
        set_op(2, 32'h7F800000, 32'h00000000, 1);
        wait_quiet("t3_quiet", 200);
        check("t3_data", last_data[2], 32'hFFC00000);
        check("t3_err", last_err[2], 0);

        // randomized traffic
        @(negedge clk);
        raise_pct = 40;
        for (int i = 0; i < N; i++) begin
            force_en[i] = 1'b0;
            send_left[i] = 12;
        end
        wait_quiet("rand_quiet", 3000);
        raise_pct = 100;

        // hung multiplier -> timeout response, then DRAIN blocks grants
        @(negedge clk);
        stub_hang = 1'b1;
        set_op(2, 32'h40000000, 32'h40400000, 1);
        c = 0;
        while (model_tmo == 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("t4_timeout_seen", model_tmo, 1);
        check("t4_err", last_err[2], 1);
        check("t4_data", last_data[2], 32'h7FC00000);
        check("t4_state", dbg_state, DRAIN);
        set_op(0, 32'h40000000, 32'h40400000, 1);
        set_op(1, 32'h3FC00000, 32'h40000000, 1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("t4_drain_ready", bus.req_ready, 0);
            check("t4_drain_busy", busy, 1);
        end

        // late result is swallowed; the next products are the right ones
        stub_hang = 1'b0;
        late_req++;
        wait_quiet("t5_quiet", 300);
        check("t5_data0", last_data[0], 32'h40C00000);
        check("t5_err0", last_err[0], 0);
        check("t5_data1", last_data[1], 32'h40400000);
        check("t5_tcount", timeout_count, 1);

        // reset in the middle of WAIT_RESULT
        @(negedge clk);
        stub_hang = 1'b1;
        set_op(1, 32'h40000000, 32'h40400000, 1);
        c = 0;
        while (dbg_state != WAIT_RESULT && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("t6_reach_wait", {63'd0, dbg_state == WAIT_RESULT}, 1);
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("t6_reset");
        exp_q.delete();
        model_ptr = 0;
        model_tmo = 0;
        stub_hang = 1'b0;
        grant_log.delete();
        set_op(0, 32'h3F800000, 32'h3F800000, 1);
        set_op(1, 32'hC0000000, 32'h40200000, 1);
        set_op(3, 32'h40000000, 32'h40400000, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_quiet("t6_quiet", 300);
        check("t6_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        check("t6_data1", last_data[1], 32'hC0A00000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
